// File: rtl/e203_tb_irq_injector_if.sv
// EXU commit stream (valid + PC) observed by the interrupt injector.
interface e203_tb_irq_injector_if #(
  parameter int PC_SIZE = 32
);
  logic               cmt_valid;
  logic [PC_SIZE-1:0] cmt_pc;

  modport master (output cmt_valid, cmt_pc);
  modport slave  (input  cmt_valid, cmt_pc);
endinterface

// File: rtl/e203_tb_irq_injector.sv
// Synthesizable interrupt stimulus source: arms on a commit PC, then raises irq_o after
// LFSR-driven delays and drops it when the handler commits; stops after enough tohost writes.
module e203_tb_irq_injector #(
  parameter int                 PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0] PC_ARM     = 32'h8000015C,
  parameter logic [PC_SIZE-1:0] PC_HANDLER = 32'h800000A6,
  parameter logic [PC_SIZE-1:0] PC_TOHOST  = 32'h80000086,
  parameter logic [31:0]        STOP_CNT   = 32'd32,
  parameter logic [15:0]        DLY_MASK   = 16'h03FF,
  parameter logic [15:0]        LFSR_SEED  = 16'hACE1,
  parameter int                 MAX_WAIT   = 4096
) (
  input  logic                          hfclk,
  input  logic                          rst_n,
  input  logic                          en_i,
  e203_tb_irq_injector_if.slave         cmt,
  output logic                          irq_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [15:0]                   inj_cnt_o,
  output logic [31:0]                   tohost_cnt_o
);
  localparam int                WD_W   = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {ST_ARM, ST_DELAY, ST_ASSERT, ST_STOP} state_e;

  state_e            state_q;
  logic [16:0]       cnt_q;
  logic [WD_W-1:0]   wd_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              irq_q, done_q, err_q;
  logic [15:0]       inj_cnt_q;
  logic [31:0]       tohost_cnt_q;

  logic        hit_arm, hit_handler, hit_tohost, stop;
  logic [16:0] dly;

  assign hit_arm     = cmt.cmt_valid && (cmt.cmt_pc == PC_ARM);
  assign hit_handler = cmt.cmt_valid && (cmt.cmt_pc == PC_HANDLER);
  assign hit_tohost  = cmt.cmt_valid && (cmt.cmt_pc == PC_TOHOST);
  assign stop        = (tohost_cnt_q > STOP_CNT);

  // Galois LFSR, taps 0xB400: maximal length, so a nonzero seed never reaches 0
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign dly    = {1'b0, lfsr_q & DLY_MASK} + 17'd1;

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARM;
      cnt_q        <= '0;
      wd_q         <= '0;
      lfsr_q       <= LFSR_SEED;
      irq_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      inj_cnt_q    <= '0;
      tohost_cnt_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      if (hit_tohost && (tohost_cnt_q != 32'hFFFF_FFFF)) tohost_cnt_q <= tohost_cnt_q + 32'd1;
      case (state_q)
        ST_ARM: begin
          if (hit_arm && en_i) begin
            if (stop) begin
              state_q <= ST_STOP;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= dly;
              state_q <= ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == 17'd1) begin
            state_q <= ST_ASSERT;
            irq_q   <= 1'b1;
            wd_q    <= '0;
          end else begin
            cnt_q <= cnt_q - 17'd1;
          end
        end
        ST_ASSERT: begin
          // a handler commit on the timeout cycle still counts as a clean injection
          if (hit_handler) begin
            irq_q <= 1'b0;
            if (inj_cnt_q != 16'hFFFF) inj_cnt_q <= inj_cnt_q + 16'd1;
            if (stop) begin
              state_q <= ST_STOP;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= dly;
              state_q <= ST_DELAY;
            end
          end else if (wd_q == WD_MAX) begin
            irq_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          irq_q  <= 1'b0;
          done_q <= 1'b1;
        end
      endcase
    end
  end

  assign irq_o        = irq_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign inj_cnt_o    = inj_cnt_q;
  assign tohost_cnt_o = tohost_cnt_q;
endmodule

// File: tb/tb_e203_tb_irq_injector.sv
// Randomized bench for the interrupt injector; irq timing predicted from the LFSR sequence.
module tb_e203_tb_irq_injector;
  localparam logic [31:0] PC_ARM = 32'h8000015C;
  localparam logic [31:0] PC_HDL = 32'h800000A6;
  localparam logic [31:0] PC_TOH = 32'h80000086;
  localparam logic [15:0] MASK   = 16'h000F;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        hfclk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic        irq, done, err, irq1, done1, err1;
  logic [15:0] inj, inj1;
  logic [31:0] toh, toh1;
  int          edges;
  int          n_cmp = 0, n_bad = 0, exp_inj = 0;

  e203_tb_irq_injector_if #(.PC_SIZE(32)) cmt_if ();

  e203_tb_irq_injector #(.DLY_MASK(MASK), .STOP_CNT(32'd2), .MAX_WAIT(16)) u_dut (
    .hfclk(hfclk), .rst_n(rst_n), .en_i(en), .cmt(cmt_if),
    .irq_o(irq), .done_o(done), .err_o(err), .inj_cnt_o(inj), .tohost_cnt_o(toh));

  e203_tb_irq_injector #(.DLY_MASK(16'h0000)) u_dut1 (
    .hfclk(hfclk), .rst_n(rst_n), .en_i(en), .cmt(cmt_if),
    .irq_o(irq1), .done_o(done1), .err_o(err1), .inj_cnt_o(inj1), .tohost_cnt_o(toh1));

  always #5 hfclk = ~hfclk;

  // edges since reset release; the LFSR value used at edge n is the seed stepped n-1 times
  always @(posedge hfclk or negedge rst_n)
    if (!rst_n) edges <= 0; else edges <= edges + 1;

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  function automatic int dly_at(input int n_edge);
    return int'(lfsr_at(n_edge - 1) & MASK) + 1;
  endfunction

  task automatic tick();
    @(posedge hfclk); #1;
  endtask

  task automatic set_cmt(input logic v, input logic [31:0] pc);
    cmt_if.cmt_valid = v;
    cmt_if.cmt_pc    = pc;
  endtask

  task automatic noise(input bit hdl_ok, input bit arm_ok);
    int r;
    r = $urandom_range(0, 7);
    if (r == 0 && hdl_ok)      set_cmt(1'b1, PC_HDL);
    else if (r == 1 && arm_ok) set_cmt(1'b1, PC_ARM);
    else                       set_cmt(r[0], {16'h9000, 16'($urandom)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; exp_inj = 0;
    set_cmt(1'b0, 32'h0);
    repeat (2) @(posedge hfclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic arm(output int n);
    set_cmt(1'b1, PC_ARM);
    tick();
    n = edges;
  endtask

  task automatic wait_rise(input int n_entry, input string tag);
    int d;
    d = dly_at(n_entry);
    for (int k = 1; k < d; k++) begin
      noise(1'b1, 1'b1); tick(); n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL %s_delay: irq=%b need 0 (cycle %0d of %0d)", tag, irq, k, d); end
    end
    noise(1'b1, 1'b1); tick(); n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL %s_rise: irq=%b need 1 after dly %0d", tag, irq, d); end
    set_cmt(1'b0, 32'h0);
  endtask

  task automatic handle(input int hold, input string tag, output int n);
    for (int k = 0; k < hold; k++) begin
      noise(1'b0, 1'b1); tick(); n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL %s_hold: irq=%b need 1 (cycle %0d)", tag, irq, k); end
    end
    set_cmt(1'b1, PC_HDL); tick(); n = edges; exp_inj++;
    set_cmt(1'b0, 32'h0);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL %s_drop: irq=%b need 0", tag, irq); end
    n_cmp++;
    if (inj !== 16'(exp_inj)) begin n_bad++; $display("FAIL %s_inj: inj_cnt=%0d need %0d", tag, inj, exp_inj); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (irq !== 1'b0)   begin n_bad++; $display("FAIL reset_irq: %b need 0", irq); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: %b need 0", done); end
    n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL reset_err: %b need 0", err); end
    n_cmp++; if (inj !== 16'h0)  begin n_bad++; $display("FAIL reset_inj: %0d need 0", inj); end
    n_cmp++; if (toh !== 32'h0)  begin n_bad++; $display("FAIL reset_tohost: %0d need 0", toh); end
    n_cmp++; if (irq1 !== 1'b0 || done1 !== 1'b0 || err1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_dut1: irq=%b done=%b err=%b need 0", irq1, done1, err1); end
  endtask

  task automatic test_dly1();
    do_reset();
    repeat (10) tick();
    set_cmt(1'b1, PC_ARM); tick(); set_cmt(1'b0, 32'h0);
    n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL dly1_c11: irq=%b need 0", irq1); end
    tick();
    n_cmp++; if (irq1 !== 1'b1) begin n_bad++; $display("FAIL dly1_c12: irq=%b need 1", irq1); end
    while (edges < 20) begin
      tick(); n_cmp++;
      if (irq1 !== 1'b1) begin n_bad++; $display("FAIL dly1_hold: irq=%b need 1 at cycle %0d", irq1, edges); end
    end
    set_cmt(1'b1, PC_HDL); tick(); set_cmt(1'b0, 32'h0);
    n_cmp++; if (irq1 !== 1'b0)  begin n_bad++; $display("FAIL dly1_c21: irq=%b need 0", irq1); end
    n_cmp++; if (inj1 !== 16'd1) begin n_bad++; $display("FAIL dly1_inj: inj_cnt=%0d need 1", inj1); end
  endtask

  task automatic test_en();
    int n;
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k < 3) set_cmt(1'b1, PC_ARM); else noise(1'b1, 1'b1);
      tick(); n_cmp++;
      if (irq !== 1'b0 || irq1 !== 1'b0) begin n_bad++; $display("FAIL en_low: irq=%b irq1=%b need 0", irq, irq1); end
    end
    en = 1'b1;
    arm(n);
    wait_rise(n, "en");
    handle($urandom_range(0, 10), "en", n);
  endtask

  task automatic test_random();
    int n;
    do_reset();
    arm(n);
    for (int i = 0; i < 6; i++) begin
      wait_rise(n, "rand");
      handle($urandom_range(0, 10), "rand", n);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    arm(n);
    wait_rise(n, "wd");
    for (int k = 0; k < 15; k++) begin
      noise(1'b0, 1'b1); tick(); n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL wd_hold: irq=%b need 1 (cycle %0d)", irq, k); end
    end
    set_cmt(1'b0, 32'h0); tick();
    n_cmp++; if (irq !== 1'b0)  begin n_bad++; $display("FAIL wd_irq: %b need 0", irq); end
    n_cmp++; if (err !== 1'b1)  begin n_bad++; $display("FAIL wd_err: %b need 1", err); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wd_done: %b need 1", done); end
    for (int k = 0; k < 5; k++) begin
      set_cmt(1'b1, (k[0]) ? PC_HDL : PC_ARM); tick(); n_cmp++;
      if (irq !== 1'b0 || inj !== 16'h0 || done !== 1'b1) begin
        n_bad++; $display("FAIL wd_stop: irq=%b inj=%0d done=%b need 0/0/1", irq, inj, done); end
    end
  endtask

  task automatic test_same_cycle();
    int n;
    do_reset();
    arm(n);
    wait_rise(n, "tie");
    handle(15, "tie", n);
    n_cmp++; if (err !== 1'b0)  begin n_bad++; $display("FAIL tie_err: %b need 0", err); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL tie_done: %b need 0", done); end
    wait_rise(n, "tie_next");
  endtask

  task automatic test_stop();
    int n;
    do_reset();
    arm(n);
    wait_rise(n, "stop");
    repeat (3) begin set_cmt(1'b1, PC_TOH); tick(); end
    set_cmt(1'b0, 32'h0);
    n_cmp++; if (toh !== 32'd3) begin n_bad++; $display("FAIL stop_tohost: %0d need 3", toh); end
    handle(0, "stop", n);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stop_done: %b need 1", done); end
    for (int k = 0; k < 20; k++) begin
      noise(1'b1, 1'b1); tick(); n_cmp++;
      if (irq !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL stop_hold: irq=%b done=%b need 0/1", irq, done); end
    end
    repeat (2) begin set_cmt(1'b1, PC_TOH); tick(); end
    set_cmt(1'b0, 32'h0);
    n_cmp++; if (toh !== 32'd5) begin n_bad++; $display("FAIL stop_tohost2: %0d need 5", toh); end
    // stop already true when arming: no delay phase at all
    do_reset();
    repeat (3) begin set_cmt(1'b1, PC_TOH); tick(); end
    arm(n);
    set_cmt(1'b0, 32'h0);
    n_cmp++; if (done !== 1'b1 || irq !== 1'b0) begin n_bad++; $display("FAIL stop_arm: done=%b irq=%b need 1/0", done, irq); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    set_cmt(1'b1, PC_TOH); tick();
    arm(n);
    wait_rise(n, "rmid");
    handle(2, "rmid", n);
    wait_rise(n, "rmid2");
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rmid_irq: %b need 0", irq); end
    n_cmp++; if (inj !== 16'h0 || toh !== 32'h0 || done !== 1'b0) begin
      n_bad++; $display("FAIL rmid_cnt: inj=%0d tohost=%0d done=%b need 0", inj, toh, done); end
    @(posedge hfclk); #1 rst_n = 1'b1; exp_inj = 0;
    arm(n);
    wait_rise(n, "rmid_seed");
    handle(1, "rmid_seed", n);
  endtask

  initial begin
    set_cmt(1'b0, 32'h0);
    test_reset();
    test_dly1();
    test_en();
    test_random();
    test_timeout();
    test_same_cycle();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
